// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response bundle for alu_sequencer.
//   master (requester): drives start, num1, num2, operation;
//                       receives result, done, busy, ovf, err (and rem).
//   slave  (sequencer): the reverse.
// Optional macro ALU_REM_EN adds the rem (remainder) signal.
interface alu_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [3:0]       operation;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             ovf;
    logic             err;
`ifdef ALU_REM_EN
    logic [WIDTH-1:0] rem;

    modport master (
        output start, num1, num2, operation,
        input  result, done, busy, ovf, err, rem
    );
    modport slave (
        input  start, num1, num2, operation,
        output result, done, busy, ovf, err, rem
    );
`else
    modport master (
        output start, num1, num2, operation,
        input  result, done, busy, ovf, err
    );
    modport slave (
        input  start, num1, num2, operation,
        output result, done, busy, ovf, err
    );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle arithmetic controller.
//   add (12) / sub (13) finish in one step; mult (14, shift-add) and
//   div (15, restoring) iterate one bit per clock for WIDTH clocks.
//   Opcodes below 12 are illegal and report err with result 0.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - alu_sequencer_if.slave: start/num1/num2/operation in,
//            result/done/busy/ovf/err (and rem) out, all registered
// Optional macro ALU_REM_EN: adds the rem output (division remainder).
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic            clk,
    input logic            reset,
    alu_sequencer_if.slave bus
);

    localparam logic [3:0] OP_ADD = 4'd12;
    localparam logic [3:0] OP_SUB = 4'd13;
    localparam logic [3:0] OP_MUL = 4'd14;
    localparam logic [3:0] OP_DIV = 4'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic [WIDTH-1:0]   b_r;
    // mult: {partial product, remaining multiplier bits}
    // div:  {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   result_r;
    logic               done_r;
    logic               busy_r;
    logic               ovf_r;
    logic               err_r;
`ifdef ALU_REM_EN
    logic [WIDTH-1:0]   rem_r;
`endif

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] iter_next;

    always_comb begin
        add_sum   = {1'b0, bus.num1} + {1'b0, bus.num2};
        sub_diff  = {1'b0, bus.num1} - {1'b0, bus.num2};
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, b_r};
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_r});
        // When div_ge the true difference is < b_r, so WIDTH bits suffice.
        // With b_r = 0 every step "succeeds": quotient = all ones and the
        // remainder ends up as the dividend shifted in whole.
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_r) : div_shift[WIDTH-1:0];
        if (is_div)
            iter_next = {div_rem, prod[WIDTH-2:0], div_ge};
        else if (prod[0])
            iter_next = {mul_sum, prod[WIDTH-1:1]};
        else
            iter_next = {1'b0, prod[2*WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            b_r      <= '0;
            prod     <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
`ifdef ALU_REM_EN
            rem_r    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        b_r    <= bus.num2;
                        busy_r <= 1'b1;
                        ovf_r  <= 1'b0;
                        err_r  <= 1'b0;
                        cnt    <= CNT_W'(WIDTH - 1);
                        case (bus.operation)
                            OP_ADD: begin
                                result_r <= add_sum[WIDTH-1:0];
                                ovf_r    <= add_sum[WIDTH];
                                done_r   <= 1'b1;
                                state    <= DONE;
`ifdef ALU_REM_EN
                                rem_r    <= '0;
`endif
                            end
                            OP_SUB: begin
                                result_r <= sub_diff[WIDTH-1:0];
                                ovf_r    <= sub_diff[WIDTH];
                                done_r   <= 1'b1;
                                state    <= DONE;
`ifdef ALU_REM_EN
                                rem_r    <= '0;
`endif
                            end
                            OP_MUL: begin
                                prod   <= {{WIDTH{1'b0}}, bus.num1};
                                is_div <= 1'b0;
                                state  <= RUN;
                            end
                            OP_DIV: begin
                                prod   <= {{WIDTH{1'b0}}, bus.num1};
                                is_div <= 1'b1;
                                state  <= RUN;
                            end
                            default: begin
                                result_r <= '0;
                                err_r    <= 1'b1;
                                done_r   <= 1'b1;
                                state    <= DONE;
`ifdef ALU_REM_EN
                                rem_r    <= '0;
`endif
                            end
                        endcase
                    end
                end
                RUN: begin
                    prod <= iter_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        result_r <= iter_next[WIDTH-1:0];
                        done_r   <= 1'b1;
                        state    <= DONE;
                        if (is_div) begin
                            ovf_r <= 1'b0;
                            err_r <= (b_r == '0);
                        end else begin
                            ovf_r <= |iter_next[2*WIDTH-1:WIDTH];
                            err_r <= 1'b0;
                        end
`ifdef ALU_REM_EN
                        rem_r <= is_div ? iter_next[2*WIDTH-1:WIDTH] : '0;
`endif
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
    assign bus.ovf    = ovf_r;
    assign bus.err    = err_r;
`ifdef ALU_REM_EN
    assign bus.rem    = rem_r;
`endif

endmodule
